// File: rtl/click_pkg.sv
// Shared types and constants for the click decoder.
package click_pkg;

  localparam int CNT_W = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

endpackage

// File: rtl/click_decoder_edge_detect.sv
// Registered level with combinational rise/fall strobes.
// The level register resets high, so a button already held when reset
// releases does not look like a fresh press.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // Track the previous level every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/click_decoder.sv
// Button gesture decoder: single click, double click and long press.
//
// state  | meaning
// IDLE   | waiting for a press
// PRESS1 | first press held, timing toward a long press
// GAP    | released after a short press, waiting for a second press
// PRESS2 | second press held, a double click on release
// LONG   | long press reported, waiting for the release
module click_decoder
  import click_pkg::*;
#(
  parameter int LONG_CYCLES = 1000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_level,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;

  edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  // Gesture FSM with registered pulses and busy flag; the counter is
  // cleared on every state change so it never exceeds the active limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state <= PRESS1;
              busy  <= 1'b1;
            end
          end
          PRESS1: begin
            if (fall) begin
              state <= GAP;
              cnt   <= '0;
            end else if (cnt == LONG_LAST) begin
              state      <= LONG;
              cnt        <= '0;
              long_press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (rise) begin
              state <= PRESS2;
              cnt   <= '0;
            end else if (cnt == GAP_LAST) begin
              state        <= IDLE;
              cnt          <= '0;
              single_click <= 1'b1;
              busy         <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PRESS2: begin
            cnt <= '0;
            if (fall) begin
              state        <= IDLE;
              double_click <= 1'b1;
              busy         <= 1'b0;
            end
          end
          LONG: begin
            cnt <= '0;
            if (fall) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
